hazard_ctrl_unit: RTL and testbench

- Sequential hazard control unit; successor to the combinational hazard detector.
- Sits beside the decode stage and observes ID operands, EX load information and the control-flow events from EX.
- Generates a pipeline stall, per-stage buffer flushes and a PC hold.
- Generalised over register-address width, multi-cycle load-use stall depth, interrupt drain length, flush depth and number of pipeline buffers.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_cmp.sv | 23 ++
 rtl/hazard_ctrl_unit.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit: FSM states,
// pipeline-buffer indices and a small parameter helper.
package hazard_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_STALL,
    INT_DRAIN,
    INT_ENTER,
    RET_FLUSH
  } state_t;

  localparam int BUF_IFID  = 0;
  localparam int BUF_IDEX  = 1;
  localparam int BUF_EXMEM = 2;
  localparam int BUF_MEMWB = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID really reads, on either operand.
module hazard_cmp #(
  parameter int REG_AW = 3
) (
  input  logic              mem_read,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [REG_AW-1:0] src,
  input  logic              src_vld,
  input  logic [REG_AW-1:0] dst,
  input  logic              dst_vld,
  output logic              hit
);

  logic src_hit;
  logic dst_hit;

  // Bitwise AND with the valid bit keeps an undriven operand from matching.
  assign src_hit = src_vld & (src == wr_addr);
  assign dst_hit = dst_vld & (dst == wr_addr);
  assign hit     = mem_read & (src_hit | dst_hit);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Sequential hazard control: load-use stalls, branch/return flushes and
// interrupt drain/entry, with a down-counter sizing each multi-cycle sequence.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int               REG_AW         = 3,
  parameter int               N_BUF          = 4,
  parameter int               LOAD_STALL_CYC = 1,
  parameter int               INT_DRAIN_CYC  = 2,
  parameter int               RET_FLUSH_CYC  = 3,
  parameter logic [N_BUF-1:0] RET_FLUSH_MASK = 4'b0011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] wr_addr_ex,
  input  logic [REG_AW-1:0] src_id,
  input  logic              src_vld_id,
  input  logic [REG_AW-1:0] dst_id,
  input  logic              dst_vld_id,
  input  logic              int_req,
  input  logic              branch_taken,
  input  logic              ret,
  output logic              stall,
  output logic [N_BUF-1:0]  flush,
  output logic              pc_hold,
  output logic              int_ack,
  output logic              busy
);

  localparam int CNT_MAX = max3(LOAD_STALL_CYC, INT_DRAIN_CYC, RET_FLUSH_CYC);
  localparam int CW      = $clog2(CNT_MAX) + 1;

  // The IDLE cycle that detects an event is itself the first cycle of the
  // load stall / return flush, so the counter covers the remaining ones.
  localparam logic [CW-1:0] LOAD_CNT_INIT =
    CW'((LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0);
  localparam logic [CW-1:0] RET_CNT_INIT =
    CW'((RET_FLUSH_CYC > 1) ? RET_FLUSH_CYC - 2 : 0);
  localparam logic [CW-1:0] INT_CNT_INIT = CW'(INT_DRAIN_CYC - 1);

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            int_pend;
  logic            int_pend_next;
  logic            busy_reg;

  logic            lu_hit;
  logic            stall_c;
  logic [N_BUF-1:0] flush_c;
  logic            pc_hold_c;
  logic            int_ack_c;

  logic [N_BUF-1:0] mask_br;
  logic [N_BUF-1:0] mask_bub;
  logic [N_BUF-1:0] mask_int;

  for (genvar gi = 0; gi < N_BUF; gi++) begin : g_mask
    assign mask_br[gi]  = (gi == BUF_IFID) || (gi == BUF_IDEX);
    assign mask_bub[gi] = (gi == BUF_IDEX);
    assign mask_int[gi] = (gi != BUF_MEMWB);
  end

  hazard_cmp #(
    .REG_AW (REG_AW)
  ) u_cmp (
    .mem_read (mem_read_ex),
    .wr_addr  (wr_addr_ex),
    .src      (src_id),
    .src_vld  (src_vld_id),
    .dst      (dst_id),
    .dst_vld  (dst_vld_id),
    .hit      (lu_hit)
  );

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    int_pend_next = int_pend;
    stall_c       = 1'b0;
    flush_c       = '0;
    pc_hold_c     = 1'b0;
    int_ack_c     = 1'b0;

    case (state)
      IDLE: begin
        if (ret) begin
          flush_c       = RET_FLUSH_MASK;
          pc_hold_c     = 1'b1;
          int_pend_next = int_pend | int_req;
          if (RET_FLUSH_CYC > 1) begin
            state_next = RET_FLUSH;
            cnt_next   = RET_CNT_INIT;
          end
        end else if (branch_taken) begin
          // The dependent instruction is flushed, so a load-use hit is moot.
          flush_c       = mask_br;
          int_pend_next = int_pend | int_req;
        end else if (lu_hit) begin
          stall_c       = 1'b1;
          flush_c       = mask_bub;
          int_pend_next = int_pend | int_req;
          if (LOAD_STALL_CYC > 1) begin
            state_next = LOAD_STALL;
            cnt_next   = LOAD_CNT_INIT;
          end
        end else if (int_req || int_pend) begin
          stall_c       = 1'b1;
          pc_hold_c     = 1'b1;
          int_pend_next = 1'b0;
          state_next    = INT_DRAIN;
          cnt_next      = INT_CNT_INIT;
        end
      end

      LOAD_STALL: begin
        stall_c       = 1'b1;
        flush_c       = mask_bub;
        int_pend_next = int_pend | int_req;
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end

      INT_DRAIN: begin
        stall_c   = 1'b1;
        pc_hold_c = 1'b1;
        if (branch_taken || ret) flush_c = mask_br;
        if (cnt == '0) state_next = INT_ENTER;
        else           cnt_next   = cnt - CW'(1);
      end

      INT_ENTER: begin
        int_ack_c  = 1'b1;
        flush_c    = mask_int;
        state_next = IDLE;
      end

      RET_FLUSH: begin
        flush_c       = RET_FLUSH_MASK;
        pc_hold_c     = 1'b1;
        int_pend_next = int_pend | int_req;
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CW'(1);
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      int_pend <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      int_pend <= int_pend_next;
      busy_reg <= (state_next != IDLE);
    end
  end

  // Reset gates the combinational IDLE decode so outputs drop immediately.
  assign stall   = rst & stall_c & ~flush_c[BUF_IFID];
  assign flush   = flush_c & {N_BUF{rst}};
  assign pc_hold = rst & pc_hold_c;
  assign int_ack = rst & int_ack_c;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a default instance and a deep-load-stall
// instance, each checked cycle by cycle against a queue of expected outputs.
module tb_hazard_ctrl_unit;

  typedef struct {
    string      tag;
    logic       stall;
    logic [3:0] flush;
    logic       pc_hold;
    logic       int_ack;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic       mem_read_ex, src_vld_id, dst_vld_id, int_req, branch_taken, ret;
  logic [2:0] wr_addr_ex, src_id, dst_id;
  logic       stall, pc_hold, int_ack, busy;
  logic [3:0] flush;

  // REG_AW=4, LOAD_STALL_CYC=3 instance
  logic       b_mem_read_ex, b_src_vld_id, b_dst_vld_id, b_int_req, b_branch_taken, b_ret;
  logic [3:0] b_wr_addr_ex, b_src_id, b_dst_id;
  logic       b_stall, b_pc_hold, b_int_ack, b_busy;
  logic [3:0] b_flush;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst),
    .mem_read_ex(mem_read_ex), .wr_addr_ex(wr_addr_ex),
    .src_id(src_id), .src_vld_id(src_vld_id),
    .dst_id(dst_id), .dst_vld_id(dst_vld_id),
    .int_req(int_req), .branch_taken(branch_taken), .ret(ret),
    .stall(stall), .flush(flush), .pc_hold(pc_hold),
    .int_ack(int_ack), .busy(busy)
  );

  hazard_ctrl_unit #(.REG_AW(4), .LOAD_STALL_CYC(3)) dut_m (
    .clk(clk), .rst(rst),
    .mem_read_ex(b_mem_read_ex), .wr_addr_ex(b_wr_addr_ex),
    .src_id(b_src_id), .src_vld_id(b_src_vld_id),
    .dst_id(b_dst_id), .dst_vld_id(b_dst_vld_id),
    .int_req(b_int_req), .branch_taken(b_branch_taken), .ret(b_ret),
    .stall(b_stall), .flush(b_flush), .pc_hold(b_pc_hold),
    .int_ack(b_int_ack), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic push_a(input string tag, input logic st, input logic [3:0] fl,
                        input logic ph, input logic ia, input logic bz);
    exp_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.pc_hold = ph; e.int_ack = ia; e.busy = bz;
    q_a.push_back(e);
  endtask

  task automatic push_b(input string tag, input logic st, input logic [3:0] fl,
                        input logic ph, input logic ia, input logic bz);
    exp_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.pc_hold = ph; e.int_ack = ia; e.busy = bz;
    q_b.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_a();
    mem_read_ex = 0; wr_addr_ex = 0; src_id = 0; src_vld_id = 0;
    dst_id = 0; dst_vld_id = 0; int_req = 0; branch_taken = 0; ret = 0;
  endtask

  task automatic idle_b();
    b_mem_read_ex = 0; b_wr_addr_ex = 0; b_src_id = 0; b_src_vld_id = 0;
    b_dst_id = 0; b_dst_vld_id = 0; b_int_req = 0; b_branch_taken = 0; b_ret = 0;
  endtask

  // Sample one tick before each rising edge; one line per transaction.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #4;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        $display("A %-10s stall=%b flush=%b pc_hold=%b int_ack=%b busy=%b",
                 e.tag, stall, flush, pc_hold, int_ack, busy);
        check({e.tag, ".stall"},   stall,   e.stall);
        check({e.tag, ".flush"},   flush,   e.flush);
        check({e.tag, ".pc_hold"}, pc_hold, e.pc_hold);
        check({e.tag, ".int_ack"}, int_ack, e.int_ack);
        check({e.tag, ".busy"},    busy,    e.busy);
        check({e.tag, ".excl"},    stall & flush[0], 1'b0);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        $display("B %-10s stall=%b flush=%b pc_hold=%b int_ack=%b busy=%b",
                 e.tag, b_stall, b_flush, b_pc_hold, b_int_ack, b_busy);
        check({e.tag, ".stall"},   b_stall,   e.stall);
        check({e.tag, ".flush"},   b_flush,   e.flush);
        check({e.tag, ".pc_hold"}, b_pc_hold, e.pc_hold);
        check({e.tag, ".int_ack"}, b_int_ack, e.int_ack);
        check({e.tag, ".busy"},    b_busy,    e.busy);
        check({e.tag, ".excl"},    b_stall & b_flush[0], 1'b0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_a();
    idle_b();
    tick();

    // outputs held at 0 during reset even with active inputs
    ret = 1; int_req = 1; mem_read_ex = 1; wr_addr_ex = 3; src_id = 3; src_vld_id = 1;
    b_mem_read_ex = 1; b_wr_addr_ex = 4'hA; b_dst_id = 4'hA; b_dst_vld_id = 1;
    push_a("rst0", 0, 4'b0000, 0, 0, 0); push_b("b_rst0", 0, 4'b0000, 0, 0, 0); tick();
    push_a("rst1", 0, 4'b0000, 0, 0, 0); push_b("b_rst1", 0, 4'b0000, 0, 0, 0); tick();
    idle_a(); idle_b(); rst = 1'b1;
    push_a("post_rst", 0, 4'b0000, 0, 0, 0); push_b("b_postrst", 0, 4'b0000, 0, 0, 0); tick();

    // single-cycle load-use on src
    mem_read_ex = 1; wr_addr_ex = 3; src_id = 3; src_vld_id = 1;
    push_a("lu_src", 1, 4'b0010, 0, 0, 0); tick();
    idle_a();
    push_a("lu_after", 0, 4'b0000, 0, 0, 0); tick();

    // operand valid bits gate the match
    mem_read_ex = 1; wr_addr_ex = 3; src_id = 3; dst_id = 3;
    push_a("lu_novld", 0, 4'b0000, 0, 0, 0); tick();
    idle_a(); mem_read_ex = 1; wr_addr_ex = 5; dst_id = 5; dst_vld_id = 1;
    push_a("lu_dst", 1, 4'b0010, 0, 0, 0); tick();
    idle_a(); mem_read_ex = 1; wr_addr_ex = 3'b111; src_id = 3'b011; src_vld_id = 1;
    push_a("lu_msb", 0, 4'b0000, 0, 0, 0); tick();
    idle_a(); wr_addr_ex = 2; src_id = 2; src_vld_id = 1;
    push_a("lu_noload", 0, 4'b0000, 0, 0, 0); tick();

    // branch beats load-use
    idle_a(); branch_taken = 1; mem_read_ex = 1; wr_addr_ex = 4; src_id = 4; src_vld_id = 1;
    push_a("br_lu", 0, 4'b0011, 0, 0, 0); tick();
    idle_a();
    push_a("br_after", 0, 4'b0000, 0, 0, 0); tick();

    // interrupt drain and entry
    int_req = 1;
    push_a("int_t0", 1, 4'b0000, 1, 0, 0); tick();
    int_req = 0;
    push_a("int_t1", 1, 4'b0000, 1, 0, 1); tick();
    push_a("int_t2", 1, 4'b0000, 1, 0, 1); tick();
    push_a("int_t3", 0, 4'b0111, 0, 1, 1); tick();
    push_a("int_t4", 0, 4'b0000, 0, 0, 0); tick();

    // ret wins over branch and load-use
    ret = 1; branch_taken = 1; mem_read_ex = 1; wr_addr_ex = 1; src_id = 1; src_vld_id = 1;
    push_a("ret_t0", 0, 4'b0011, 1, 0, 0); tick();
    idle_a();
    push_a("ret_t1", 0, 4'b0011, 1, 0, 1); tick();
    push_a("ret_t2", 0, 4'b0011, 1, 0, 1); tick();
    push_a("ret_t3", 0, 4'b0000, 0, 0, 0); tick();

    // interrupt during return flush becomes pending
    ret = 1;
    push_a("rp_t0", 0, 4'b0011, 1, 0, 0); tick();
    ret = 0; int_req = 1;
    push_a("rp_t1", 0, 4'b0011, 1, 0, 1); tick();
    int_req = 0;
    push_a("rp_t2", 0, 4'b0011, 1, 0, 1); tick();
    push_a("rp_t3", 1, 4'b0000, 1, 0, 0); tick();
    push_a("rp_t4", 1, 4'b0000, 1, 0, 1); tick();
    push_a("rp_t5", 1, 4'b0000, 1, 0, 1); tick();
    push_a("rp_t6", 0, 4'b0111, 0, 1, 1); tick();
    push_a("rp_t7", 0, 4'b0000, 0, 0, 0); tick();

    // branch inside drain flushes without restarting the count
    int_req = 1;
    push_a("bd_t0", 1, 4'b0000, 1, 0, 0); tick();
    int_req = 0; branch_taken = 1;
    push_a("bd_t1", 0, 4'b0011, 1, 0, 1); tick();
    branch_taken = 0;
    push_a("bd_t2", 1, 4'b0000, 1, 0, 1); tick();
    push_a("bd_t3", 0, 4'b0111, 0, 1, 1); tick();
    push_a("bd_t4", 0, 4'b0000, 0, 0, 0); tick();

    // load-use outranks a simultaneous interrupt
    int_req = 1; mem_read_ex = 1; wr_addr_ex = 6; dst_id = 6; dst_vld_id = 1;
    push_a("li_t0", 1, 4'b0010, 0, 0, 0); tick();
    idle_a(); int_req = 1;
    push_a("li_t1", 1, 4'b0000, 1, 0, 0); tick();
    int_req = 0;
    push_a("li_t2", 1, 4'b0000, 1, 0, 1); tick();
    push_a("li_t3", 1, 4'b0000, 1, 0, 1); tick();
    push_a("li_t4", 0, 4'b0111, 0, 1, 1); tick();
    push_a("li_t5", 0, 4'b0000, 0, 0, 0); tick();

    // asynchronous reset in the middle of a drain
    int_req = 1;
    push_a("md_t0", 1, 4'b0000, 1, 0, 0); tick();
    int_req = 0;
    push_a("md_t1", 1, 4'b0000, 1, 0, 1); tick();
    #2;
    check("md_pre.stall", stall, 1'b1);
    rst = 1'b0;
    #1;
    check("md_rst.stall",   stall,   1'b0);
    check("md_rst.pc_hold", pc_hold, 1'b0);
    check("md_rst.busy",    busy,    1'b0);
    check("md_rst.flush",   flush,   4'b0000);
    check("md_rst.int_ack", int_ack, 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_a($sformatf("md_idle%0d", i), 0, 4'b0000, 0, 0, 0); tick();
    end

    // deep load stall on the REG_AW=4 instance
    b_mem_read_ex = 1; b_wr_addr_ex = 4'hA; b_dst_id = 4'hA; b_dst_vld_id = 1;
    push_b("mlu_c1", 1, 4'b0010, 0, 0, 0); tick();
    idle_b();
    push_b("mlu_c2", 1, 4'b0010, 0, 0, 1); tick();
    push_b("mlu_c3", 1, 4'b0010, 0, 0, 1); tick();
    push_b("mlu_c4", 0, 4'b0000, 0, 0, 0); tick();
    b_mem_read_ex = 1; b_wr_addr_ex = 4'hA; b_dst_id = 4'h2; b_dst_vld_id = 1; b_src_id = 4'hA;
    push_b("mlu_msb", 0, 4'b0000, 0, 0, 0); tick();
    idle_b();
    push_b("mlu_idle", 0, 4'b0000, 0, 0, 0); tick();
    tick();

    check("q_a.empty", q_a.size(), 0);
    check("q_b.empty", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
